// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush enables, E-stage forwarding, dmem wait/timeout FSM.
// Latency: combinational controls in the hazard cycle; a miss stalls until ack or MEM_TIMEOUT stalled cycles.
module hazard_ctrl #(
    parameter logic [1:0] LOAD_SEL    = 2'b10,
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       waddrE,
    input  logic [1:0]       wb_selE,
    input  logic [4:0]       waddrM,
    input  logic             reg_wrM,
    input  logic [4:0]       waddrW,
    input  logic             reg_wrW,
    input  logic             br_takenE,
    input  logic             dmem_reqM,
    input  logic             dmem_ackM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              loaduse, miss;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] wm, input logic wrm,
                                           input logic [4:0] ww, input logic wrw);
        if (wrm && wm != 5'd0 && wm == rs)
            return 2'b01;
        else if (wrw && ww != 5'd0 && ww == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign loaduse = (wb_selE == LOAD_SEL) && (waddrE != 5'd0) && (waddrE == rs1D || waddrE == rs2D);
    assign miss    = dmem_reqM && !dmem_ackM;

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        mem_fault = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        state_d   = state_q;
        wait_d    = wait_q;
        if (!rst) begin
            forwardAE = fwd_sel(rs1E, waddrM, reg_wrM, waddrW, reg_wrW);
            forwardBE = fwd_sel(rs2E, waddrM, reg_wrM, waddrW, reg_wrW);
            case (state_q)
                RUN: begin
                    if (miss) begin
                        {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
                        state_d = MEM_WAIT;
                        wait_d  = WC_W'(1);
                    end else if (br_takenE) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (loaduse) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ackM) begin
                        // M advances this cycle, so the younger hazards resolve normally
                        if (br_takenE) begin
                            flushD = 1'b1;
                            flushE = 1'b1;
                        end else if (loaduse) begin
                            stallF = 1'b1;
                            stallD = 1'b1;
                            flushE = 1'b1;
                        end
                        state_d = RUN;
                        wait_d  = '0;
                    end else begin
                        {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
                        if (wait_q == WC_W'(MEM_TIMEOUT - 1))
                            state_d = FAULT;
                        else
                            wait_d = wait_q + WC_W'(1);
                    end
                end
                FAULT: begin
                    mem_fault = 1'b1;
                    flushD    = 1'b1;
                    flushE    = 1'b1;
                    flushM    = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end
                default: begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stallF && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl: a cycle-level reference model queues expected
// outputs per driven cycle; an independent monitor pops and compares on the falling edge.
module tb_hazard_ctrl;

    localparam int TMO   = 16;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW;
    logic [1:0] wb_selE;
    logic reg_wrM, reg_wrW, br_takenE, dmem_reqM, dmem_ackM;
    logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mem_fault;
    logic [1:0] forwardAE, forwardBE;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_SEL(2'b10), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .waddrE(waddrE), .wb_selE(wb_selE),
        .waddrM(waddrM), .reg_wrM(reg_wrM),
        .waddrW(waddrW), .reg_wrW(reg_wrW),
        .br_takenE(br_takenE), .dmem_reqM(dmem_reqM), .dmem_ackM(dmem_ackM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_fault(mem_fault), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, we, wm, ww;
        logic [1:0] wbe;
        bit rwm, rww, br, req, ack;
    } stim_t;

    typedef struct {
        logic [8:0] ctrl;   // {stallF,D,E,M, flushD,E,M,W, mem_fault}
        logic [3:0] fwd;    // {forwardAE, forwardBE}
        int         sc;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit done   = 0;

    // reference model state: stalled cycles spent on the current miss (0 = none), pending fault, counter
    int  m_age   = 0;
    bit  m_fault = 0;
    int  m_cnt   = 0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0;
        s.we = 0; s.wm = 0; s.ww = 0; s.wbe = 0;
        s.rwm = 0; s.rww = 0; s.br = 0; s.req = 0; s.ack = 0;
        return s;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (s.rwm && s.wm != 0 && s.wm == rs) return 2'b01;
        if (s.rww && s.ww != 0 && s.ww == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit sF, sD, sE, sM, fD, fE, fM, fW, mf, lu;
        @(posedge clk);
        #1;
        rst = s.rst; rs1D = s.rs1d; rs2D = s.rs2d; rs1E = s.rs1e; rs2E = s.rs2e;
        waddrE = s.we; wb_selE = s.wbe; waddrM = s.wm; reg_wrM = s.rwm;
        waddrW = s.ww; reg_wrW = s.rww; br_takenE = s.br; dmem_reqM = s.req; dmem_ackM = s.ack;
        {sF, sD, sE, sM, fD, fE, fM, fW, mf} = '0;
        lu = (s.wbe == 2'b10) && s.we != 0 && (s.we == s.rs1d || s.we == s.rs2d);
        e.cyc = cyc;
        if (s.rst) begin
            e.fwd = 4'b0;
            e.sc  = 0;
            m_age = 0; m_fault = 0; m_cnt = 0;
        end else begin
            e.fwd = {ref_fwd(s.rs1e, s), ref_fwd(s.rs2e, s)};
            e.sc  = m_cnt;
            if (m_fault) begin
                {fD, fE, fM, mf} = 4'b1111;
                m_fault = 0;
            end else if (m_age > 0 && !s.ack) begin
                {sF, sD, sE, sM, fW} = 5'b11111;
                m_age++;
                if (m_age == TMO) begin
                    m_fault = 1;
                    m_age = 0;
                end
            end else if (m_age == 0 && s.req && !s.ack) begin
                {sF, sD, sE, sM, fW} = 5'b11111;
                m_age = 1;
            end else begin
                m_age = 0;
                if (s.br) {fD, fE} = 2'b11;
                else if (lu) {sF, sD, fE} = 3'b111;
            end
            if (sF && m_cnt < CMAX) m_cnt++;
        end
        e.ctrl = {sF, sD, sE, sM, fD, fE, fM, fW, mf};
        exp_q.push_back(e);
        cyc++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mem_fault} !== e.ctrl) begin
                fails++;
                $display("FAIL ctrl cyc=%0d got=%b exp=%b", e.cyc,
                         {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mem_fault}, e.ctrl);
            end
            checks++;
            if ({forwardAE, forwardBE} !== e.fwd) begin
                fails++;
                $display("FAIL fwd cyc=%0d got=%b exp=%b", e.cyc, {forwardAE, forwardBE}, e.fwd);
            end
            checks++;
            if (int'(stall_cycles) != e.sc) begin
                fails++;
                $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.cyc, stall_cycles, e.sc);
            end
        end
    end

    initial begin
        stim_t s;
        int slow;
        s = idle();
        s.rst = 1;
        drive(s); drive(s);

        // forwarding: M, W only, waddrM=0, M beats W on operand B
        s = idle(); s.rs1e = 5; s.wm = 5; s.rwm = 1; drive(s);
        s = idle(); s.rs1e = 5; s.ww = 5; s.rww = 1; drive(s);
        s = idle(); s.rs1e = 0; s.wm = 0; s.rwm = 1; drive(s);
        s = idle(); s.rs2e = 9; s.wm = 9; s.rwm = 1; s.ww = 9; s.rww = 1; drive(s);

        // load-use bubble, then clean
        s = idle(); s.we = 7; s.wbe = 2'b10; s.rs2d = 7; drive(s);
        s = idle(); drive(s);
        s = idle(); s.we = 0; s.wbe = 2'b10; s.rs1d = 0; drive(s);

        // miss acked after 3 stalled cycles
        s = idle(); s.req = 1;
        repeat (3) drive(s);
        s.ack = 1; drive(s);
        s = idle(); drive(s);

        // miss never acked: timeout then fault pulse
        s = idle(); s.req = 1;
        repeat (TMO + 1) drive(s);
        s = idle(); drive(s);

        // branch beats load-use; branch deferred while waiting
        s = idle(); s.br = 1; s.we = 7; s.wbe = 2'b10; s.rs1d = 7; drive(s);
        s = idle(); s.req = 1; drive(s);
        s.br = 1; drive(s);
        s.ack = 1; drive(s);

        // reset in the second wait cycle
        s = idle(); s.req = 1; drive(s); drive(s);
        s = idle(); s.rst = 1; drive(s);
        s = idle(); drive(s); drive(s);

        for (int i = 0; i < 3000; i++) begin
            slow = ((i / 150) % 3 == 2);
            s.rst  = ($urandom_range(0, 99) == 0);
            s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
            s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
            s.we   = 5'($urandom_range(0, 3)); s.wm   = 5'($urandom_range(0, 3));
            s.ww   = 5'($urandom_range(0, 3)); s.wbe  = 2'($urandom_range(0, 3));
            s.rwm  = 1'($urandom_range(0, 1)); s.rww  = 1'($urandom_range(0, 1));
            s.br   = ($urandom_range(0, 5) == 0);
            s.req  = ($urandom_range(0, 3) == 0);
            s.ack  = slow ? 1'b0 : ($urandom_range(0, 2) == 0);
            drive(s);
        end
        done = 1;
    end

    initial begin
        int guard = 0;
        while (!done && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (!done || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain done=%0d pending=%0d exp_pending=0", done, exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
